// File: rtl/bsg_manycore_vcache_dma_arbiter_pkg.sv
// Shared types for the vcache DMA arbiter: FSM state encoding and DMA packet sizing.
// A DMA packet is packed as {write_not_read, addr}.
package bsg_manycore_vcache_dma_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PKT,
    FILL,
    EVICT
  } bsg_vcache_dma_arb_state_e;

  function automatic int dma_pkt_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_manycore_vcache_dma_arbiter_rr.sv
// Round-robin grant: picks the first request at or after the pointer; the pointer
// moves past the granted requester only when yumi_i accepts the grant.
module bsg_manycore_vcache_dma_arbiter_rr #(
  parameter int num_p = 2,
  localparam int id_width_lp = $clog2(num_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [num_p-1:0]       reqs_i,
  input  logic                   yumi_i,
  output logic                   v_o,
  output logic [id_width_lp-1:0] id_o
);

  logic [id_width_lp-1:0] ptr_r;
  logic [id_width_lp:0]   back_shift;
  logic [num_p-1:0]       rot;
  logic [id_width_lp:0]   sum;

  // Rotate so that bit 0 of rot is the requester at the pointer.
  assign back_shift = (id_width_lp + 1)'(num_p) - {1'b0, ptr_r};
  assign rot = (reqs_i >> ptr_r) | (reqs_i << back_shift);

  always_comb begin
    v_o  = 1'b0;
    id_o = '0;
    sum  = '0;
    for (int i = num_p - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_r} + (id_width_lp + 1)'(i);
      if (rot[i]) begin
        v_o  = 1'b1;
        id_o = (sum >= (id_width_lp + 1)'(num_p))
               ? id_width_lp'(sum - (id_width_lp + 1)'(num_p))
               : sum[id_width_lp-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_r <= '0;
    end else if (yumi_i) begin
      ptr_r <= (id_o == id_width_lp'(num_p - 1)) ? '0 : id_o + 1'b1;
    end
  end

endmodule

// File: rtl/bsg_manycore_vcache_dma_arbiter.sv
// Shares one DMA port among num_caches_p vcache DMA interfaces, one transaction at a time.
// Define BSG_MANYCORE_VCACHE_DMA_ARB_STATS_EN to enable the busy_cycles_o counter.
module bsg_manycore_vcache_dma_arbiter
  import bsg_manycore_vcache_dma_arbiter_pkg::*;
#(
  parameter int num_caches_p          = 2,
  parameter int addr_width_p          = 32,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  parameter int dma_data_width_p      = 32
) (
  input  logic                                                   clk_i,
  input  logic                                                   reset_i,
  input  logic [num_caches_p-1:0][dma_pkt_width(addr_width_p)-1:0] dma_pkt_i,
  input  logic [num_caches_p-1:0]                                dma_pkt_v_i,
  output logic [num_caches_p-1:0]                                dma_pkt_yumi_o,
  output logic [num_caches_p-1:0][dma_data_width_p-1:0]          dma_data_o,
  output logic [num_caches_p-1:0]                                dma_data_v_o,
  input  logic [num_caches_p-1:0]                                dma_data_ready_i,
  input  logic [num_caches_p-1:0][dma_data_width_p-1:0]          dma_data_i,
  input  logic [num_caches_p-1:0]                                dma_data_v_i,
  output logic [num_caches_p-1:0]                                dma_data_yumi_o,
  output logic [dma_pkt_width(addr_width_p)-1:0]                 dma_pkt_o,
  output logic                                                   dma_pkt_v_o,
  input  logic                                                   dma_pkt_yumi_i,
  input  logic [dma_data_width_p-1:0]                            dma_data_fill_i,
  input  logic                                                   dma_data_fill_v_i,
  output logic                                                   dma_data_fill_ready_o,
  output logic [dma_data_width_p-1:0]                            dma_data_evict_o,
  output logic                                                   dma_data_evict_v_o,
  input  logic                                                   dma_data_evict_yumi_i,
  output logic [31:0]                                            busy_cycles_o
);

  localparam int pkt_width_lp = dma_pkt_width(addr_width_p);
  localparam int beats_lp     = block_size_in_words_p * data_width_p / dma_data_width_p;
  localparam int sel_width_lp = $clog2(num_caches_p);
  localparam int cnt_width_lp = safe_clog2(beats_lp);

  bsg_vcache_dma_arb_state_e state_r;
  logic [sel_width_lp-1:0]   sel_r;
  logic [cnt_width_lp-1:0]   cnt_r;

  logic                    grant_v;
  logic [sel_width_lp-1:0] grant_id;
  logic                    rr_yumi;
  logic                    last_beat;

  // Pointer advances once per grant, at the IDLE->PKT transition.
  assign rr_yumi   = (state_r == IDLE) & grant_v;
  assign last_beat = (cnt_r == cnt_width_lp'(beats_lp - 1));

  bsg_manycore_vcache_dma_arbiter_rr #(
    .num_p(num_caches_p)
  ) rr (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .reqs_i (dma_pkt_v_i),
    .yumi_i (rr_yumi),
    .v_o    (grant_v),
    .id_o   (grant_id)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      sel_r   <= '0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_v) begin
            sel_r   <= grant_id;
            state_r <= PKT;
          end
        end
        PKT: begin
          if (dma_pkt_yumi_i) begin
            cnt_r   <= '0;
            state_r <= dma_pkt_i[sel_r][pkt_width_lp-1] ? EVICT : FILL;
          end
        end
        FILL: begin
          if (dma_data_fill_v_i & dma_data_ready_i[sel_r]) begin
            if (last_beat) state_r <= IDLE;
            else           cnt_r   <= cnt_r + 1'b1;
          end
        end
        EVICT: begin
          if (dma_data_evict_yumi_i) begin
            if (last_beat) state_r <= IDLE;
            else           cnt_r   <= cnt_r + 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Only the selected cache's lanes are ever driven; everything is 0 in IDLE.
  always_comb begin
    dma_pkt_o             = '0;
    dma_pkt_v_o           = 1'b0;
    dma_pkt_yumi_o        = '0;
    dma_data_o            = '0;
    dma_data_v_o          = '0;
    dma_data_yumi_o       = '0;
    dma_data_fill_ready_o = 1'b0;
    dma_data_evict_o      = '0;
    dma_data_evict_v_o    = 1'b0;
    case (state_r)
      PKT: begin
        dma_pkt_o             = dma_pkt_i[sel_r];
        dma_pkt_v_o           = 1'b1;
        dma_pkt_yumi_o[sel_r] = dma_pkt_yumi_i;
      end
      FILL: begin
        dma_data_o[sel_r]     = dma_data_fill_i;
        dma_data_v_o[sel_r]   = dma_data_fill_v_i;
        dma_data_fill_ready_o = dma_data_ready_i[sel_r];
      end
      EVICT: begin
        dma_data_evict_o       = dma_data_i[sel_r];
        dma_data_evict_v_o     = dma_data_v_i[sel_r];
        dma_data_yumi_o[sel_r] = dma_data_evict_yumi_i;
      end
      default: ;
    endcase
  end

`ifdef BSG_MANYCORE_VCACHE_DMA_ARB_STATS_EN
  logic [31:0] busy_cycles_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_cycles_r <= '0;
    end else if ((state_r != IDLE) && (busy_cycles_r != '1)) begin
      busy_cycles_r <= busy_cycles_r + 32'd1;
    end
  end

  assign busy_cycles_o = busy_cycles_r;
`else
  assign busy_cycles_o = '0;
`endif

endmodule
